// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, hex glyph table
// and the tick-counter width helper.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order gfedcba, indexed by nibble value.
  localparam logic [6:0] HEX_PATTERNS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int tick_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational nibble-to-glyph lookup driven by the package pattern table.
module seg_hex_lut
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_PATTERNS[i_nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment driver with per-slot ghosting guard.
// Define SEVENSEG_SCAN_LZB_EN to compile in leading-zero blanking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS      = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  output logic [6:0]             segments,
  output logic                   dp_out,
  output logic [NDIGITS-1:0]     anodes
);

  localparam int TW = tick_width(REFRESH_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD_END = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  logic [TW-1:0]          r_tick;
  logic [IW-1:0]          r_idx;
  logic [4*NDIGITS-1:0]   r_sh_data;
  logic [NDIGITS-1:0]     r_sh_dp;
  logic [NDIGITS-1:0]     r_sh_blank;

  logic                   w_guard;
  logic                   w_dark;
  logic [3:0]             w_nibble;
  logic [6:0]             w_hex_seg;
  logic [NDIGITS-1:0]     w_lz_mask;
  logic [NDIGITS-1:0]     w_anodes;

  assign w_guard  = (r_tick < GUARD_END);
  assign w_nibble = r_sh_data[{r_idx, 2'b00} +: 4];

  seg_hex_lut u_hex_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

`ifdef SEVENSEG_SCAN_LZB_EN
  // Walk down from the top digit; the run of blankable digits stops at the
  // first non-zero nibble or lit decimal point. Digit 0 always displays.
  logic w_lz_run;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_lz_mask = '0;
    w_lz_run  = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      w_lz_run     = w_lz_run & (r_sh_data[4*i +: 4] == 4'h0) & ~r_sh_dp[i];
      w_lz_mask[i] = w_lz_run;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  assign w_dark   = w_guard | r_sh_blank[r_idx] | w_lz_mask[r_idx];
  assign w_anodes = w_dark ? '1 : ~(NDIGITS'(1) << r_idx);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= '0;
      r_idx      <= '0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      segments   <= SEG_BLANK;
      dp_out     <= 1'b1;
      anodes     <= '1;
    end else begin
      if (load) begin
        r_sh_data  <= data;
        r_sh_dp    <= dp;
        r_sh_blank <= blank;
      end
      if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
      anodes   <= w_anodes;
      segments <= w_dark ? SEG_BLANK : w_hex_seg;
      dp_out   <= w_dark ? 1'b1 : ~r_sh_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a cycle-count reference model predicts every
// registered output; a separate monitor compares each cycle.
module tb_sevenseg_scan;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
  } obs_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [4*N-1:0] data;
  logic [N-1:0]   dp;
  logic [N-1:0]   blank;
  logic [6:0]     segments;
  logic           dp_out;
  logic [N-1:0]   anodes;

  sevenseg_scan #(.NDIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .dp       (dp),
    .blank    (blank),
    .segments (segments),
    .dp_out   (dp_out),
    .anodes   (anodes)
  );

  always #5 clk = ~clk;

  // Glyphs straight from the display datasheet table (gfedcba, active-low).
  bit [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: cycles elapsed since reset plus the latched display content.
  int       m_t;
  bit [3:0] m_nib [N];
  bit       m_dp  [N];
  bit       m_blk [N];

  obs_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  name, $time, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
  endtask

  function automatic bit lz_dark(input int idx);
    if (idx == 0) return 1'b0;
`ifdef SEVENSEG_SCAN_LZB_EN
    for (int j = idx; j < N; j++)
      if (m_nib[j] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int tick = m_t % RD;
    int idx  = (m_t / RD) % N;
    bit dark = (tick < BC) || m_blk[idx] || lz_dark(idx);
    o.an  = dark ? {N{1'b1}} : ~(N'(1) << idx);
    o.seg = dark ? 7'h7F : glyph[m_nib[idx]];
    o.dp  = dark ? 1'b1 : !m_dp[idx];
    return o;
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < N; i++) begin
      m_nib[i] = 4'h0;
      m_dp[i]  = 1'b0;
      m_blk[i] = 1'b1;
    end
  endtask

  // One clock: drive at negedge, predict what the next rising edge registers,
  // advance the model, then enqueue the prediction once that edge has happened.
  task automatic cycle(input bit rst, input bit ld, input bit [4*N-1:0] d,
                       input bit [N-1:0] p, input bit [N-1:0] b);
    obs_t e;
    @(negedge clk);
    reset = rst; load = ld; data = d; dp = p; blank = b;
    if (rst) begin
      e = '{an: {N{1'b1}}, seg: 7'h7F, dp: 1'b1};
      model_reset();
    end else begin
      e = model_out();
      if (ld)
        for (int i = 0; i < N; i++) begin
          m_nib[i] = d[4*i +: 4];
          m_dp[i]  = p[i];
          m_blk[i] = b[i];
        end
      m_t++;
    end
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: outputs are stable at the falling edge, so compare there.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("display", {anodes, segments, dp_out}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [4*N-1:0] rd;
    reset = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0;
    model_reset();

    repeat (3) cycle(1'b1, 1'b0, '0, '0, '0);

    cycle(1'b0, 1'b1, 16'h12AF, 4'b0000, 4'b0000);
    idle(20);

    cycle(1'b0, 1'b1, 16'h12AF, 4'b0001, 4'b0100);
    idle(16);

    cycle(1'b0, 1'b1, 16'h0030, 4'b0000, 4'b0000);
    idle(16);
    cycle(1'b0, 1'b1, 16'h0030, 4'b1000, 4'b0000);
    idle(16);

    // Reset during digit 2's lit phase with a competing load.
    cycle(1'b1, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b1, 16'h4567, 4'b0000, 4'b0000);
    while ((m_t % (N*RD)) != 2*RD + BC) idle(1);
    cycle(1'b1, 1'b1, 16'h89AB, 4'b1111, 4'b0000);
    idle(16);

    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        rd[4*i +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom);
      cycle($urandom_range(63, 0) == 0, $urandom_range(7, 0) == 0, rd,
            ($urandom_range(3, 0) == 0) ? N'($urandom) : '0,
            ($urandom_range(3, 0) == 0) ? N'($urandom) : '0);
    end
    idle(4);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
